// File: rtl/inst_encoder.sv
// RV32I instruction encoder for the test-program loader: symbolic op in, machine word
// plus sequential word address out, with immediate range checks and LI expansion.
module inst_encoder #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_JAL   = 7'h6F;
  localparam logic [6:0] OPC_JALR  = 7'h67;
  localparam logic [6:0] OPC_BR    = 7'h63;
  localparam logic [6:0] OPC_LD    = 7'h03;
  localparam logic [6:0] OPC_ST    = 7'h23;
  localparam logic [6:0] OPC_OPI   = 7'h13;
  localparam logic [6:0] OPC_OP    = 7'h33;

  typedef enum logic {S_ONE, S_LI2} state_t;

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_ST};
  endfunction

  // b holds imm[12:1]: b[11]=imm[12], b[10]=imm[11]
  function automatic logic [31:0] enc_b(input logic [11:0] b, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {b[11], b[9:4], rs2, rs1, f3, b[3:0], b[10], OPC_BR};
  endfunction

  // j holds imm[20:1]: j[19]=imm[20], j[10]=imm[11], j[18:11]=imm[19:12]
  function automatic logic [31:0] enc_j(input logic [19:0] j, input logic [4:0] rd);
    return {j[19], j[9:0], j[10], j[18:11], rd, OPC_JAL};
  endfunction

  function automatic logic [31:0] enc_r(input logic f7alt, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {1'b0, f7alt, 5'b0, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [2:0] funct3_of(input logic [5:0] op);
    case (op)
      6'd5, 6'd11, 6'd16, 6'd24, 6'd29:        return 3'd1;
      6'd12, 6'd17, 6'd19, 6'd30:              return 3'd2;
      6'd20, 6'd31:                            return 3'd3;
      6'd6, 6'd13, 6'd21, 6'd32:               return 3'd4;
      6'd7, 6'd14, 6'd25, 6'd26, 6'd33, 6'd34: return 3'd5;
      6'd8, 6'd22, 6'd35:                      return 3'd6;
      6'd9, 6'd23, 6'd36:                      return 3'd7;
      default:                                 return 3'd0;
    endcase
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_out_valid;
  logic [31:0]         r_out_inst;
  logic [31:0]         r_pend;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_err;

  logic signed [31:0]  w_imm_s;
  logic                w_i_ok, w_b_ok, w_j_ok, w_sh_ok;
  logic [2:0]          w_f3;
  logic                w_alt;
  logic [19:0]         w_hi;
  logic [11:0]         w_lo;
  logic [31:0]         w_word, w_addi;
  logic                w_legal, w_two;
  logic                w_in_ready, w_out_hs, w_ld_first, w_ld_pend, w_bad;

  assign w_imm_s = signed'(in_imm);
  assign w_i_ok  = (w_imm_s >= -2048) && (w_imm_s <= 2047);
  assign w_b_ok  = !in_imm[0] && (w_imm_s >= -4096) && (w_imm_s <= 4094);
  assign w_j_ok  = !in_imm[0] && (w_imm_s >= -1048576) && (w_imm_s <= 1048574);
  assign w_sh_ok = (in_imm[31:5] == 27'd0);
  assign w_f3    = funct3_of(in_op);
  assign w_alt   = (in_op == 6'd26) || (in_op == 6'd28) || (in_op == 6'd34);
  // ADDI sign-extends lo, so hi absorbs the borrow when lo is negative
  assign w_hi    = in_imm[31:12] + {19'd0, in_imm[11]};
  assign w_lo    = in_imm[11:0];

  always_comb begin
    w_word  = '0;
    w_addi  = '0;
    w_legal = 1'b0;
    w_two   = 1'b0;
    case (in_op) inside
      6'd0: begin w_legal = 1'b1; w_word = enc_u(in_imm[31:12], in_rd, OPC_LUI); end
      6'd1: begin w_legal = 1'b1; w_word = enc_u(in_imm[31:12], in_rd, OPC_AUIPC); end
      6'd2: begin w_legal = w_j_ok; w_word = enc_j(in_imm[20:1], in_rd); end
      6'd3: begin
        w_legal = w_i_ok;
        w_word  = enc_i(in_imm[11:0], in_rs1, 3'd0, in_rd, OPC_JALR);
      end
      [6'd4:6'd9]: begin
        w_legal = w_b_ok;
        w_word  = enc_b(in_imm[12:1], in_rs2, in_rs1, w_f3);
      end
      [6'd10:6'd14]: begin
        w_legal = w_i_ok;
        w_word  = enc_i(in_imm[11:0], in_rs1, w_f3, in_rd, OPC_LD);
      end
      [6'd15:6'd17]: begin
        w_legal = w_i_ok;
        w_word  = enc_s(in_imm[11:0], in_rs2, in_rs1, w_f3);
      end
      [6'd18:6'd23]: begin
        w_legal = w_i_ok;
        w_word  = enc_i(in_imm[11:0], in_rs1, w_f3, in_rd, OPC_OPI);
      end
      [6'd24:6'd26]: begin
        w_legal = w_sh_ok;
        w_word  = enc_i({1'b0, w_alt, 5'd0, in_imm[4:0]}, in_rs1, w_f3, in_rd, OPC_OPI);
      end
      [6'd27:6'd36]: begin
        w_legal = 1'b1;
        w_word  = enc_r(w_alt, in_rs2, in_rs1, w_f3, in_rd);
      end
      6'd37: begin
        w_legal = 1'b1;
        if (w_hi == 20'd0) begin
          w_word = enc_i(w_lo, 5'd0, 3'd0, in_rd, OPC_OPI);
        end else if (w_lo == 12'd0) begin
          w_word = enc_u(w_hi, in_rd, OPC_LUI);
        end else begin
          w_word = enc_u(w_hi, in_rd, OPC_LUI);
          w_addi = enc_i(w_lo, in_rd, 3'd0, in_rd, OPC_OPI);
          w_two  = 1'b1;
        end
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_out_hs = r_out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_ld_first  = 1'b0;
    w_ld_pend   = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      S_ONE: begin
        w_in_ready = (!r_out_valid || out_ready) && !start && !rst;
        if (in_valid && w_in_ready) begin
          if (w_legal) begin
            w_ld_first = 1'b1;
            if (w_two) w_state_nxt = S_LI2;
          end else begin
            w_bad = 1'b1;
          end
        end
      end
      S_LI2: begin
        if (w_out_hs) begin
          w_ld_pend   = 1'b1;
          w_state_nxt = S_ONE;
        end
      end
      default: w_state_nxt = S_ONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || start) r_state <= S_ONE;
    else              r_state <= w_state_nxt;
  end

  // Output register stage: word, valid, address counter, error pulse
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_out_valid <= 1'b0;
      r_addr      <= BASE_A;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_bad;
      if (w_out_hs) r_addr <= r_addr + 1'b1;
      if (w_ld_first || w_ld_pend) r_out_valid <= 1'b1;
      else if (w_out_hs)           r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             r_out_inst <= '0;
    else if (w_ld_first) r_out_inst <= w_word;
    else if (w_ld_pend)  r_out_inst <= r_pend;
  end

  always_ff @(posedge clk) begin
    if (w_ld_first) r_pend <= w_addi;
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_inst  = r_out_inst;
  assign out_addr  = r_addr;
  assign err       = r_err;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with a 2-bit address so wrap-around is exercised.
module tb_inst_encoder;
  localparam int ADDR_W = 2;
  localparam int BASE   = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [5:0]        in_op = '0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]       in_imm = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              err;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] got_inst[$];
  int          got_addr[$];
  int          got_cyc[$];
  logic [31:0] exp_inst[$];
  int          exp_addr[$];

  inst_encoder #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs settle 1ns after the rising edge, so the negedge sees the coming handshake
  always @(negedge clk) begin
    if (!rst && !start && out_valid && out_ready) begin
      got_inst.push_back(out_inst);
      got_addr.push_back(int'(out_addr));
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expw(input logic [31:0] inst, input int addr);
    exp_inst.push_back(inst);
    exp_addr.push_back(addr);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int t;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 50);
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_bad(input string tag, input logic [5:0] op, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm, input int addr);
    send(op, 5'd1, rs1, rs2, imm);
    @(negedge clk);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_no_valid"}, out_valid, 0);
    chk({tag, "_addr"}, out_addr, addr);
    @(negedge clk);
    chk({tag, "_err_pulse"}, err, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // Back-to-back ALU ops, then LI variants and branch/jump/store/shift words
    send(6'd18, 5'd1, 5'd0, 5'd0, 32'd5);          expw(32'h00500093, 0);
    send(6'd27, 5'd3, 5'd1, 5'd2, 32'd0);          expw(32'h002081B3, 1);
    send(6'd28, 5'd3, 5'd1, 5'd2, 32'd0);          expw(32'h402081B3, 2);
    send(6'd37, 5'd5, 5'd0, 5'd0, 32'h12345FFF);   expw(32'h123462B7, 3);
                                                   expw(32'hFFF28293, 0);
    send(6'd37, 5'd5, 5'd0, 5'd0, 32'd7);          expw(32'h00700293, 1);
    send(6'd37, 5'd5, 5'd0, 5'd0, 32'h00005000);   expw(32'h000052B7, 2);
    send(6'd4,  5'd0, 5'd1, 5'd2, 32'd8);          expw(32'h00208463, 3);
    send(6'd2,  5'd1, 5'd0, 5'd0, 32'd16);         expw(32'h010000EF, 0);
    send(6'd18, 5'd0, 5'd0, 5'd0, 32'hFFFFF800);   expw(32'h80000013, 1);
    send(6'd4,  5'd0, 5'd0, 5'd0, 32'hFFFFF000);   expw(32'h80000063, 2);
    send(6'd24, 5'd1, 5'd1, 5'd0, 32'd31);         expw(32'h01F09093, 3);
    send(6'd26, 5'd1, 5'd1, 5'd0, 32'd3);          expw(32'h4030D093, 0);
    send(6'd17, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);   expw(32'hFE20AE23, 1);
    idle(3);

    send_bad("bad_addi_2048", 6'd18, 5'd0, 5'd0, 32'd2048, 2);
    send_bad("bad_beq_odd",   6'd4,  5'd1, 5'd2, 32'd3, 2);
    send_bad("bad_op50",      6'd50, 5'd0, 5'd0, 32'd0, 2);
    send_bad("bad_slli_32",   6'd24, 5'd1, 5'd0, 32'd32, 2);
    send_bad("bad_beq_4096",  6'd4,  5'd1, 5'd2, 32'd4096, 2);

    // Backpressure across both halves of a two-word LI
    out_ready = 1'b0;
    in_op = 6'd37; in_rd = 5'd5; in_imm = 32'h12345FFF; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_lui_valid", out_valid, 1);
      chk("bp_lui_inst", out_inst, 32'h123462B7);
      chk("bp_lui_addr", out_addr, 2);
      chk("bp_lui_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("li2_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_addi_valid", out_valid, 1);
      chk("bp_addi_inst", out_inst, 32'hFFF28293);
      chk("bp_addi_addr", out_addr, 3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    expw(32'h123462B7, 2);
    expw(32'hFFF28293, 3);
    idle(2);

    // Restart while an LI is half done
    send(6'd18, 5'd2, 5'd0, 5'd0, 32'd1);          expw(32'h00100113, 0);
    idle(2);
    out_ready = 1'b0;
    send(6'd37, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    start = 1'b1;
    @(negedge clk);
    chk("start_in_ready", in_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_out_valid", out_valid, 0);
    chk("start_out_addr", out_addr, BASE);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(6'd18, 5'd1, 5'd0, 5'd0, 32'd5);          expw(32'h00500093, 0);
    idle(3);

    chk("word_count", got_inst.size(), exp_inst.size());
    for (int i = 0; i < exp_inst.size() && i < got_inst.size(); i++) begin
      chk($sformatf("word%0d_inst", i), got_inst[i], exp_inst[i]);
      chk($sformatf("word%0d_addr", i), got_addr[i], exp_addr[i]);
    end
    if (got_cyc.size() >= 3) begin
      chk("b2b_gap1", got_cyc[1] - got_cyc[0], 1);
      chk("b2b_gap2", got_cyc[2] - got_cyc[1], 1);
    end else begin
      chk("b2b_words", got_cyc.size(), 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
